// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-stage types and constants
package cpu_pkg;
  typedef enum logic [1:0] {BOOT, FETCH, HOLD, FAULT} state_t;
  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
endpackage

// File: rtl/ifetch_outreg.sv
// ifetch_outreg: one-entry instruction output register with valid/ready and flush
module ifetch_outreg import cpu_pkg::*; #(
  parameter int PC_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               load,
  input  logic               ready,
  input  logic [INSTR_W-1:0] din_instr,
  input  logic [PC_W-1:0]    din_pc,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    pc
);
  // flush beats load; a transfer without a new load empties the entry
  always_ff @(posedge clk)
    if (rst) begin
      valid <= 1'b0;
      instr <= '0;
      pc <= '0;
    end else if (flush) valid <= 1'b0;
    else if (load) begin
      valid <= 1'b1;
      instr <= din_instr;
      pc <= din_pc;
    end else if (ready) valid <= 1'b0;
endmodule

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: pc sequencer and fetch FSM in front of instr_mem (optional perf counters: IFETCH_PERF_CNT_EN)
module ifetch_ctrl import cpu_pkg::*; #(
  parameter int PC_W = 32,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF),
  parameter int IMEM_DEPTH = 256
) (
  input  logic               clk,
  input  logic               rst,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc,
  input  logic               if_ready,
  output logic               fault,
  output logic [PC_W-1:0]    fault_pc
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_stall
`endif
);
  state_t state, state_nx;
  logic [PC_W-1:0] pc;
  logic bad, cap, set_fault, flush;
  assign imem_addr = pc;
  assign bad = (pc[1:0] != 2'b00) || ({2'b00, pc[PC_W-1:2]} >= PC_W'(IMEM_DEPTH));
  // state register
  always_ff @(posedge clk)
    state <= rst ? BOOT : state_nx;
  // next state: FAULT is absorbing, redirect restarts fetch, stall parks in HOLD
  always_comb
    state_nx = state == FAULT ? FAULT :
               flush ? FETCH :
               state == BOOT ? FETCH :
               set_fault ? FAULT :
               (if_valid && !if_ready) ? HOLD : FETCH;
  // control outputs: redirect has priority over capture and fault
  always_comb begin
    flush = redirect_valid && state != FAULT;
    cap = !flush && (state == FETCH || state == HOLD) && !bad && (!if_valid || if_ready);
    set_fault = !flush && state == FETCH && bad;
  end
  // program counter and sticky fault capture
  always_ff @(posedge clk)
    if (rst) begin
      pc <= RESET_PC;
      fault <= 1'b0;
      fault_pc <= '0;
    end else begin
      pc <= flush ? redirect_pc : cap ? pc + PC_W'(PC_STEP) : pc;
      if (set_fault) begin
        fault <= 1'b1;
        fault_pc <= pc;
      end
    end
  ifetch_outreg #(.PC_W(PC_W)) u_outreg (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .load(cap),
    .ready(if_ready),
    .din_instr(imem_rdata),
    .din_pc(pc),
    .valid(if_valid),
    .instr(if_instr),
    .pc(if_pc)
  );
`ifdef IFETCH_PERF_CNT_EN
  // saturating capture and stall counters
  always_ff @(posedge clk)
    if (rst) begin
      perf_fetched <= '0;
      perf_stall <= '0;
    end else begin
      if (cap && perf_fetched != '1) perf_fetched <= perf_fetched + 32'd1;
      if (state == HOLD && perf_stall != '1) perf_stall <= perf_stall + 32'd1;
    end
`endif
endmodule
